// File: rtl/move_validator.sv
// Piece move/rotation legality checker: tests up to three candidate poses
// (one per clock) against a registered 6x6 occupancy window.
package game_state_pkg;
  // 4x4 shape masks, bit r*4+c, indexed [piece_type][rotation]
  localparam logic [15:0] PIECE_MASK [7][4] = '{
    '{16'h00F0, 16'h4444, 16'h0F00, 16'h2222},  // I
    '{16'h0660, 16'h0660, 16'h0660, 16'h0660},  // O
    '{16'h0072, 16'h0262, 16'h0270, 16'h0232},  // T
    '{16'h0036, 16'h0462, 16'h0360, 16'h0231},  // S
    '{16'h0063, 16'h0264, 16'h0630, 16'h0132},  // Z
    '{16'h0071, 16'h0226, 16'h0470, 16'h0322},  // J
    '{16'h0074, 16'h0622, 16'h0170, 16'h0223}   // L
  };
endpackage

module move_validator #(
  parameter int BOARD_WIDTH  = 10,
  parameter int BOARD_HEIGHT = 20,
  localparam int XW = $clog2(BOARD_WIDTH),
  localparam int YW = $clog2(BOARD_HEIGHT)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      move_cmd,
  input  logic [2:0]      piece_type,
  input  logic [1:0]      piece_rot,
  input  logic [XW-1:0]   piece_x,
  input  logic [YW-1:0]   piece_y,
  input  logic [5:0][5:0] window,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_ok,
  output logic            resp_lock,
  output logic [XW-1:0]   new_x,
  output logic [YW-1:0]   new_y,
  output logic [1:0]      new_rot
);
  localparam logic [2:0] CMD_LEFT = 3'd1, CMD_RIGHT = 3'd2, CMD_DOWN = 3'd3,
                         CMD_CW = 3'd4, CMD_CCW = 3'd5;

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;
  state_t state;

  logic [2:0]      cmd_q, type_q;
  logic [1:0]      rot_q, idx;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [5:0][5:0] win_q;

  // registered result of the previously tested candidate
  logic            p_vld, p_hit, p_lock, p_last, p_dxn, p_dxp, p_dy;
  logic [1:0]      p_rot;

  logic            illegal, is_rot, dxn, dxp, dy, guard, wcoll, coll, lock_c, last;
  logic [1:0]      cand_rot;
  logic [15:0]     mask;
  logic [2:0]      ix, iy;
  logic [XW-1:0]   nx;
  logic [YW-1:0]   ny;

  assign req_ready = (state == IDLE);
  assign illegal   = (cmd_q > CMD_CCW) || (type_q == 3'd7);
  assign is_rot    = (cmd_q == CMD_CW) || (cmd_q == CMD_CCW);
  assign cand_rot  = (cmd_q == CMD_CW) ? rot_q + 2'd1 :
                     (cmd_q == CMD_CCW) ? rot_q - 2'd1 : rot_q;
  // rotation kicks: idx 0 -> dx=0, 1 -> dx=-1, 2 -> dx=+1
  assign dxn   = (cmd_q == CMD_LEFT)  || (is_rot && idx == 2'd1);
  assign dxp   = (cmd_q == CMD_RIGHT) || (is_rot && idx == 2'd2);
  assign dy    = (cmd_q == CMD_DOWN);
  assign guard = (dxn && x_q == '0) || (dxp && (&x_q)) || (dy && (&y_q));
  assign mask  = illegal ? 16'h0 : game_state_pkg::PIECE_MASK[type_q][cand_rot];

  always_comb begin
    wcoll = 1'b0;
    ix    = '0;
    iy    = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ix = 3'(1 + c) + (dxp ? 3'd1 : 3'd0) - (dxn ? 3'd1 : 3'd0);
        iy = 3'(1 + r) + (dy ? 3'd1 : 3'd0);
        if (mask[4'(r * 4 + c)] && win_q[ix][iy]) wcoll = 1'b1;
      end
    end
  end

  assign coll   = illegal || guard || wcoll;
  assign lock_c = !illegal && !guard && wcoll && dy;
  assign last   = illegal || !is_rot || (idx == 2'd2);
  assign nx     = p_dxn ? x_q - XW'(1) : p_dxp ? x_q + XW'(1) : x_q;
  assign ny     = p_dy ? y_q + YW'(1) : y_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cmd_q      <= '0;
      type_q     <= '0;
      rot_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      win_q      <= '0;
      idx        <= '0;
      p_vld      <= 1'b0;
      p_hit      <= 1'b0;
      p_lock     <= 1'b0;
      p_last     <= 1'b0;
      p_dxn      <= 1'b0;
      p_dxp      <= 1'b0;
      p_dy       <= 1'b0;
      p_rot      <= '0;
      resp_valid <= 1'b0;
      resp_ok    <= 1'b0;
      resp_lock  <= 1'b0;
      new_x      <= '0;
      new_y      <= '0;
      new_rot    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cmd_q  <= move_cmd;
          type_q <= piece_type;
          rot_q  <= piece_rot;
          x_q    <= piece_x;
          y_q    <= piece_y;
          win_q  <= window;
          idx    <= '0;
          p_vld  <= 1'b0;
          state  <= CHECK;
        end
        CHECK: begin
          if (p_vld && !p_hit) begin
            resp_valid <= 1'b1;
            resp_ok    <= 1'b1;
            resp_lock  <= 1'b0;
            new_x      <= nx;
            new_y      <= ny;
            new_rot    <= p_rot;
            state      <= RESP;
          end else if (p_vld && p_last) begin
            resp_valid <= 1'b1;
            resp_ok    <= 1'b0;
            resp_lock  <= p_lock;
            new_x      <= x_q;
            new_y      <= y_q;
            new_rot    <= rot_q;
            state      <= RESP;
          end else begin
            p_vld  <= 1'b1;
            p_hit  <= coll;
            p_lock <= lock_c;
            p_last <= last;
            p_dxn  <= dxn;
            p_dxp  <= dxp;
            p_dy   <= dy;
            p_rot  <= cand_rot;
            idx    <= idx + 2'd1;
          end
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
